// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and the snooped CDB broadcast record for the out-of-order core.
package cdb_arbiter_pkg;

  localparam int unsigned TAG_LEN     = 4;
  localparam int unsigned CDB_TAG_W   = TAG_LEN + 1;
  localparam int unsigned CDB_NUM_REQ = 5;
  localparam int unsigned CDB_PTR_W   = $clog2(CDB_NUM_REQ);

  localparam int unsigned CDB_ALU = 0;
  localparam int unsigned CDB_MUL = 1;
  localparam int unsigned CDB_DIV = 2;
  localparam int unsigned CDB_BR  = 3;
  localparam int unsigned CDB_LSQ = 4;

  typedef struct packed {
    logic             valid;
    logic [TAG_LEN:0] rob_tag;
    logic [31:0]      value;
    logic [31:0]      next_pc;
    logic             mispred;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake bundle plus the registered CDB broadcast.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = CDB_NUM_REQ,
  parameter int unsigned TAG_W   = CDB_TAG_W
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ*32-1:0]    req_value;
  logic [NUM_REQ*32-1:0]    req_next_pc;
  logic [NUM_REQ-1:0]       req_mispred;
  logic [NUM_REQ-1:0]       req_ready;

  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [31:0]              cdb_value;
  logic [31:0]              cdb_next_pc;
  logic                     cdb_mispred;

  modport master (
    output req_valid, req_tag, req_value, req_next_pc, req_mispred,
    input  req_ready,
    input  cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_mispred
  );

  modport slave (
    input  req_valid, req_tag, req_value, req_next_pc, req_mispred,
    output req_ready,
    output cdb_valid, cdb_tag, cdb_value, cdb_next_pc, cdb_mispred
  );
endinterface

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Pure combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o,
  output logic               grant_vld_o
);

  int unsigned pos;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    pos         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr_i) + k) % NUM_REQ;
      if (!grant_vld_o && req_i[pos]) begin
        grant_vld_o   = 1'b1;
        grant_o[pos]  = 1'b1;
        grant_idx_o   = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus; registers one winner per cycle onto the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = CDB_NUM_REQ,
  parameter int unsigned TAG_W   = CDB_TAG_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  cdb_arbiter_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  cdb_t               cdb_q, cdb_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [NUM_REQ-1:0] ready;
  logic               transfer;

  logic [TAG_W-1:0]   sel_tag;
  logic [31:0]        sel_value;
  logic [31:0]        sel_next_pc;
  logic               sel_mispred;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (pick_oh),
    .grant_idx_o (pick_idx),
    .grant_vld_o (pick_vld)
  );

  // Flush and reset gate the grant itself, so neither the pointer nor the CDB sees a transfer.
  always_comb begin
    ready    = (flush || rst) ? '0 : pick_oh;
    transfer = pick_vld && !flush && !rst;
  end

  assign bus.req_ready = ready;

  // One-hot grant makes an AND-OR mux sufficient for the payload select.
  always_comb begin
    sel_tag     = '0;
    sel_value   = '0;
    sel_next_pc = '0;
    sel_mispred = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        sel_tag     = sel_tag     | bus.req_tag[i*TAG_W +: TAG_W];
        sel_value   = sel_value   | bus.req_value[i*32 +: 32];
        sel_next_pc = sel_next_pc | bus.req_next_pc[i*32 +: 32];
        sel_mispred = sel_mispred | bus.req_mispred[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      rr_ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    end
  end

  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = transfer;
    if (transfer) begin
      cdb_d.rob_tag = sel_tag;
      cdb_d.value   = sel_value;
      cdb_d.next_pc = sel_next_pc;
      cdb_d.mispred = sel_mispred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign bus.cdb_valid   = cdb_q.valid;
  assign bus.cdb_tag     = cdb_q.rob_tag;
  assign bus.cdb_value   = cdb_q.value;
  assign bus.cdb_next_pc = cdb_q.next_pc;
  assign bus.cdb_mispred = cdb_q.mispred;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grant order, wrap, flush, mid-stream reset and tag 31.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk;
  logic rst;
  logic flush;

  int unsigned vectors;
  int unsigned miscompares;

  cdb_arbiter_if #(.NUM_REQ(CDB_NUM_REQ), .TAG_W(CDB_TAG_W)) bus ();

  cdb_arbiter #(
    .NUM_REQ (CDB_NUM_REQ),
    .TAG_W   (CDB_TAG_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] tag, input logic [31:0] val,
                         input logic [31:0] npc, input logic mp);
    bus.req_tag[i*5 +: 5]      = tag;
    bus.req_value[i*32 +: 32]  = val;
    bus.req_next_pc[i*32 +: 32] = npc;
    bus.req_mispred[i]         = mp;
  endtask

  task automatic chk_cdb(input string name, input logic v, input logic [4:0] tag);
    chk({name, "_valid"}, 64'(bus.cdb_valid), 64'(v));
    chk({name, "_tag"},   64'(bus.cdb_tag),   64'(tag));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    flush = 1'b0;
    bus.req_valid   = 5'b11111;
    bus.req_tag     = '0;
    bus.req_value   = '0;
    bus.req_next_pc = '0;
    bus.req_mispred = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    @(posedge clk); #1;
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
    chk("rst_cdb_tag", 64'(bus.cdb_tag), 64'h0);
    chk("rst_cdb_value", 64'(bus.cdb_value), 64'h0);
    chk("rst_cdb_npc", 64'(bus.cdb_next_pc), 64'h0);
    chk("rst_cdb_mp", 64'(bus.cdb_mispred), 64'h0);

    // Single requester
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 5'd5, 32'h1234, 32'h0, 1'b0);
    bus.req_valid = 5'b00001;
    #1 chk("single_ready", 64'(bus.req_ready), 64'h01);
    @(posedge clk); #1;
    chk_cdb("single", 1'b1, 5'd5);
    chk("single_value", 64'(bus.cdb_value), 64'h1234);
    @(negedge clk);
    bus.req_valid = 5'b00000;
    #1 chk("idle_ready", 64'(bus.req_ready), 64'h0);
    @(posedge clk); #1;
    chk("idle_cdb_valid", 64'(bus.cdb_valid), 64'h0);
    chk("idle_value_hold", 64'(bus.cdb_value), 64'h1234);

    // All five valid from reset: order 0,1,2,3,4,0 back to back
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 5'b11111;
    for (int i = 0; i < 5; i++) set_req(i, 5'(10 + i), 32'h100 + 32'(i), 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_ready", 64'(bus.req_ready), 64'(5'b00001 << (k % 5)));
      @(posedge clk); #1;
      chk_cdb("rr", 1'b1, 5'(10 + (k % 5)));
      @(negedge clk);
    end

    // Move rr_ptr to 2, then 5'b10001 must pick 4 and wrap to 0
    bus.req_valid = 5'b00010;
    #1 chk("ptr2_ready", 64'(bus.req_ready), 64'h02);
    @(posedge clk); #1;
    chk_cdb("ptr2", 1'b1, 5'd11);
    @(negedge clk);
    bus.req_valid = 5'b10001;
    #1 chk("wrap_ready4", 64'(bus.req_ready), 64'h10);
    @(posedge clk); #1;
    chk_cdb("wrap4", 1'b1, 5'd14);
    @(negedge clk);
    bus.req_valid = 5'b00001;
    #1 chk("wrap_ready0", 64'(bus.req_ready), 64'h01);
    @(posedge clk); #1;
    chk_cdb("wrap0", 1'b1, 5'd10);

    // Flush squashes the branch grant, which is then taken once flush drops
    @(negedge clk);
    bus.req_valid = 5'b01000;
    set_req(3, 5'd7, 32'hBEEF, 32'h80000040, 1'b1);
    flush = 1'b1;
    #1 chk("flush_ready", 64'(bus.req_ready), 64'h0);
    @(posedge clk); #1;
    chk("flush_cdb_valid", 64'(bus.cdb_valid), 64'h0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("postflush_ready", 64'(bus.req_ready), 64'h08);
    @(posedge clk); #1;
    chk_cdb("postflush", 1'b1, 5'd7);
    chk("postflush_npc", 64'(bus.cdb_next_pc), 64'h80000040);
    chk("postflush_mp", 64'(bus.cdb_mispred), 64'h1);

    // Reset during a grant to requester 2 (rr_ptr 2 beforehand)
    @(negedge clk);
    bus.req_valid = 5'b00010;
    #1 chk("prerst_ready", 64'(bus.req_ready), 64'h02);
    @(posedge clk); #1;
    chk_cdb("prerst", 1'b1, 5'd11);
    @(negedge clk);
    bus.req_valid = 5'b00100;
    rst = 1'b1;
    #1 chk("midrst_ready", 64'(bus.req_ready), 64'h0);
    @(posedge clk); #1;
    chk("midrst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
    chk("midrst_cdb_value", 64'(bus.cdb_value), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 5'b00110;
    #1 chk("postrst_ready1", 64'(bus.req_ready), 64'h02);
    @(posedge clk); #1;
    chk_cdb("postrst1", 1'b1, 5'd11);
    @(negedge clk);
    bus.req_valid = 5'b00100;
    #1 chk("postrst_ready2", 64'(bus.req_ready), 64'h04);
    @(posedge clk); #1;
    chk_cdb("postrst2", 1'b1, 5'd12);

    // Tag 31 / all-ones value from the LSQ
    @(negedge clk);
    bus.req_valid = 5'b10000;
    set_req(4, 5'd31, 32'hFFFFFFFF, 32'h0, 1'b0);
    #1 chk("tag31_ready", 64'(bus.req_ready), 64'h10);
    @(posedge clk); #1;
    chk_cdb("tag31", 1'b1, 5'd31);
    chk("tag31_value", 64'(bus.cdb_value), 64'hFFFFFFFF);
    @(negedge clk);
    bus.req_valid = 5'b00000;
    @(posedge clk); #1;
    chk("final_idle_valid", 64'(bus.cdb_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
